debouncer_multi: RTL and testbench



---
 rtl/debouncer_multi.sv | 111 +++++++++++
 tb/tb_debouncer_multi.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/debouncer_multi.sv
// debouncer_multi: per-channel sync + debounce with edge, long-press and auto-repeat pulses (Clock/Reset, NoisySignal_i in; FilteredSignal_o, RisingEdge_o, FallingEdge_o, LongPress_o, Repeat_o out)
module debouncer_multi #(
  parameter int CHANNELS = 4,
  parameter int CLOCK_HZ = 10_000_000,
  parameter int PERIOD_US = 100,
  parameter logic [CHANNELS-1:0] ACTIVE_LOW = '0,
  parameter int LONG_PRESS_MS = 1000,
  parameter int REPEAT_MS = 200
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic [CHANNELS-1:0] NoisySignal_i,
  output logic [CHANNELS-1:0] FilteredSignal_o,
  output logic [CHANNELS-1:0] RisingEdge_o,
  output logic [CHANNELS-1:0] FallingEdge_o,
  output logic [CHANNELS-1:0] LongPress_o,
  output logic [CHANNELS-1:0] Repeat_o
);
  localparam int DELAY = (CLOCK_HZ / 1_000_000) * PERIOD_US - 1;
  localparam int CW = $clog2(DELAY + 1);
  localparam int PRE = CLOCK_HZ / 1000;
  localparam int PW = $clog2(PRE);
  localparam int MSMAX = LONG_PRESS_MS > REPEAT_MS ? LONG_PRESS_MS : REPEAT_MS;
  localparam int MW = $clog2(MSMAX + 1);
  localparam logic [CW-1:0] DLY = CW'(DELAY);
  localparam logic [MW-1:0] LP = MW'(LONG_PRESS_MS);
  localparam logic [MW-1:0] LP_M1 = MW'(LONG_PRESS_MS - 1);
  localparam logic [MW-1:0] RP_M1 = MW'(REPEAT_MS > 0 ? REPEAT_MS - 1 : 0);
  typedef enum logic [1:0] {IDLE, HELD, REPEAT} state_t;
  logic [CHANNELS-1:0] sync1_q, sync2_q, lvl, filt_q, filt_d, filtd_q;
  logic [PW-1:0] pre_q, pre_d;
  logic tick;
  assign lvl = sync2_q ^ ACTIVE_LOW;
  assign tick = pre_q == PW'(PRE - 1);
  assign pre_d = tick ? '0 : pre_q + 1'b1;
  assign FilteredSignal_o = filt_q;
  assign RisingEdge_o = filt_q & ~filtd_q;
  assign FallingEdge_o = ~filt_q & filtd_q;
  always_ff @(posedge Clock) begin
    if (Reset) begin
      sync1_q <= ACTIVE_LOW;
      sync2_q <= ACTIVE_LOW;
      filt_q <= '0;
      filtd_q <= '0;
      pre_q <= '0;
    end else begin
      sync1_q <= NoisySignal_i;
      sync2_q <= sync1_q;
      filt_q <= filt_d;
      filtd_q <= filt_q;
      pre_q <= pre_d;
    end
  end
  for (genvar c = 0; c < CHANNELS; c++) begin : ch
    logic [CW-1:0] cnt_q, cnt_d;
    logic diff, done;
    state_t state_q, state_d;
    logic [MW-1:0] ms_q, ms_d;
    logic lp, rp;
    assign diff = lvl[c] ^ filt_q[c];
    assign done = diff && cnt_q == DLY;
    assign filt_d[c] = done ? lvl[c] : filt_q[c];
    assign cnt_d = diff && !done ? cnt_q + 1'b1 : '0;
    // Without repeat, HELD parks the counter at LP so the long press fires only once.
    always_comb begin
      state_d = state_q;
      ms_d = ms_q;
      lp = 1'b0;
      rp = 1'b0;
      if (!filt_q[c]) begin
        state_d = IDLE;
        ms_d = '0;
      end else begin
        case (state_q)
          IDLE: if (!filtd_q[c]) begin
            state_d = HELD;
            ms_d = '0;
          end
          HELD: if (tick && ms_q != LP) begin
            if (ms_q == LP_M1) begin
              lp = 1'b1;
              state_d = REPEAT_MS > 0 ? REPEAT : HELD;
              ms_d = REPEAT_MS > 0 ? '0 : LP;
            end else ms_d = ms_q + 1'b1;
          end
          REPEAT: if (tick) begin
            rp = ms_q == RP_M1;
            ms_d = ms_q == RP_M1 ? '0 : ms_q + 1'b1;
          end
          default: begin
            state_d = IDLE;
            ms_d = '0;
          end
        endcase
      end
    end
    always_ff @(posedge Clock) begin
      if (Reset) begin
        cnt_q <= '0;
        state_q <= IDLE;
        ms_q <= '0;
      end else begin
        cnt_q <= cnt_d;
        state_q <= state_d;
        ms_q <= ms_d;
      end
    end
    assign LongPress_o[c] = lp;
    assign Repeat_o[c] = rp;
  end
endmodule

// File: tb/tb_debouncer_multi.sv
// tb_debouncer_multi: directed self-checking bench for debouncer_multi
module tb_debouncer_multi;
  logic Clock = 1'b0;
  logic Reset = 1'b1;
  logic [3:0] noisy = 4'b1000;
  logic [3:0] filt, rise, fall, lp, rep;
  int total = 0;
  int passed = 0;

  debouncer_multi #(
    .CHANNELS(4), .CLOCK_HZ(1_000_000), .PERIOD_US(4), .ACTIVE_LOW(4'b1000),
    .LONG_PRESS_MS(3), .REPEAT_MS(2)
  ) dut (
    .Clock(Clock), .Reset(Reset), .NoisySignal_i(noisy), .FilteredSignal_o(filt),
    .RisingEdge_o(rise), .FallingEdge_o(fall), .LongPress_o(lp), .Repeat_o(rep)
  );

  always #5 Clock = ~Clock;

  task automatic test_reset();
    int bad;
    bad = 0;
    Reset = 1'b1;
    repeat (3) @(negedge Clock);
    total++;
    if ({filt, rise, fall, lp, rep} !== 20'h0) $display("FAIL reset_outputs got %h want 00000", {filt, rise, fall, lp, rep});
    else passed++;
    Reset = 1'b0;
    repeat (10) begin
      @(negedge Clock);
      if ({filt, rise, fall, lp, rep} !== 20'h0) bad++;
    end
    total++;
    if (bad !== 0) $display("FAIL reset_release_quiet got %0d active cycles want 0", bad);
    else passed++;
  endtask

  task automatic test_rise_ch0();
    logic [1:0] exp;
    noisy[0] = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge Clock);
      exp = {k >= 6, k == 6};
      total++;
      if ({filt[0], rise[0]} !== exp) $display("FAIL rise_ch0 step %0d got filt/rise %b want %b", k, {filt[0], rise[0]}, exp);
      else passed++;
    end
    noisy[0] = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge Clock);
      exp = {k < 6, k == 6};
      total++;
      if ({filt[0], fall[0]} !== exp) $display("FAIL fall_ch0 step %0d got filt/fall %b want %b", k, {filt[0], fall[0]}, exp);
      else passed++;
    end
  endtask

  task automatic test_glitch_ch1();
    int bad;
    logic [2:0] exp;
    bad = 0;
    repeat (10) begin
      noisy[1] = 1'b1;
      repeat (3) begin
        @(negedge Clock);
        if (filt[1] | rise[1] | fall[1]) bad++;
      end
      noisy[1] = 1'b0;
      repeat (2) begin
        @(negedge Clock);
        if (filt[1] | rise[1] | fall[1]) bad++;
      end
    end
    repeat (6) begin
      @(negedge Clock);
      if (filt[1] | rise[1] | fall[1]) bad++;
    end
    total++;
    if (bad !== 0) $display("FAIL glitch_ch1 got %0d leaked cycles want 0", bad);
    else passed++;
    noisy[1] = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge Clock);
      exp = {k >= 6 && k <= 9, k == 6, k == 10};
      total++;
      if ({filt[1], rise[1], fall[1]} !== exp) $display("FAIL pulse4_ch1 step %0d got filt/rise/fall %b want %b", k, {filt[1], rise[1], fall[1]}, exp);
      else passed++;
      if (k == 4) noisy[1] = 1'b0;
    end
  endtask

  task automatic test_long_press();
    int t, lp_n, lp_at, rep_n, rep_first, rep_last, drop, late;
    lp_n = 0; lp_at = -1; rep_n = 0; rep_first = -1; rep_last = -1; drop = 0; late = 0;
    noisy[0] = 1'b1;
    t = 0;
    while (!rise[0] && t < 20) begin
      @(negedge Clock);
      t++;
    end
    total++;
    if (t !== 6) $display("FAIL lp_rise_latency got %0d want 6", t);
    else passed++;
    for (int k = 1; k <= 10000; k++) begin
      @(negedge Clock);
      if (lp[0]) begin
        lp_n++;
        lp_at = k;
      end
      if (rep[0]) begin
        rep_n++;
        if (rep_first < 0) rep_first = k;
        rep_last = k;
      end
      if (!filt[0]) drop++;
    end
    total++;
    if (lp_n !== 1) $display("FAIL lp_count got %0d want 1", lp_n);
    else passed++;
    total++;
    if (lp_at < 2001 || lp_at > 3000) $display("FAIL lp_window got %0d want 2001..3000", lp_at);
    else passed++;
    total++;
    if (rep_n !== 3) $display("FAIL rep_count got %0d want 3", rep_n);
    else passed++;
    total++;
    if (rep_first !== lp_at + 2000) $display("FAIL rep_first got %0d want %0d", rep_first, lp_at + 2000);
    else passed++;
    total++;
    if (rep_last !== lp_at + 6000) $display("FAIL rep_last got %0d want %0d", rep_last, lp_at + 6000);
    else passed++;
    total++;
    if (drop !== 0) $display("FAIL lp_hold_filtered got %0d low cycles want 0", drop);
    else passed++;
    noisy[0] = 1'b0;
    t = 0;
    while (!fall[0] && t < 20) begin
      @(negedge Clock);
      t++;
    end
    total++;
    if (t !== 6) $display("FAIL lp_release_latency got %0d want 6", t);
    else passed++;
    repeat (3000) begin
      @(negedge Clock);
      if (lp[0] | rep[0] | filt[0]) late++;
    end
    total++;
    if (late !== 0) $display("FAIL lp_after_release got %0d active cycles want 0", late);
    else passed++;
  endtask

  task automatic test_active_low_ch3();
    logic [1:0] exp;
    noisy[3] = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge Clock);
      exp = {k >= 6, k == 6};
      total++;
      if ({filt[3], rise[3]} !== exp) $display("FAIL actlow_press step %0d got filt/rise %b want %b", k, {filt[3], rise[3]}, exp);
      else passed++;
    end
    noisy[3] = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge Clock);
      exp = {k < 6, k == 6};
      total++;
      if ({filt[3], fall[3]} !== exp) $display("FAIL actlow_release step %0d got filt/fall %b want %b", k, {filt[3], fall[3]}, exp);
      else passed++;
    end
  endtask

  task automatic test_simultaneous();
    int t, lp0_n, lp0_at, lp2_n, fall2_at, drop;
    lp0_n = 0; lp0_at = -1; lp2_n = 0; fall2_at = -1; drop = 0;
    noisy[0] = 1'b1;
    noisy[2] = 1'b1;
    t = 0;
    while (rise === 4'b0000 && t < 20) begin
      @(negedge Clock);
      t++;
    end
    total++;
    if (rise !== 4'b0101 || t !== 6) $display("FAIL simul_rise got %b at %0d want 0101 at 6", rise, t);
    else passed++;
    for (int k = 1; k <= 3100; k++) begin
      @(negedge Clock);
      if (lp[0]) begin
        lp0_n++;
        lp0_at = k;
      end
      if (lp[2] | rep[2]) lp2_n++;
      if (fall[2]) fall2_at = k;
      if (!filt[0]) drop++;
      if (k == 1500) noisy[2] = 1'b0;
    end
    total++;
    if (fall2_at !== 1506) $display("FAIL simul_fall2 got %0d want 1506", fall2_at);
    else passed++;
    total++;
    if (lp2_n !== 0) $display("FAIL simul_ch2_nolp got %0d pulses want 0", lp2_n);
    else passed++;
    total++;
    if (lp0_n !== 1 || lp0_at < 2001 || lp0_at > 3000) $display("FAIL simul_ch0_lp got %0d pulses at %0d want 1 in 2001..3000", lp0_n, lp0_at);
    else passed++;
    total++;
    if (drop !== 0) $display("FAIL simul_ch0_held got %0d low cycles want 0", drop);
    else passed++;
  endtask

  task automatic test_reset_mid();
    int rise_n, rise_at, lp_n, lp_at, rep_at;
    rise_n = 0; rise_at = -1; lp_n = 0; lp_at = -1; rep_at = -1;
    repeat (500) @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    total++;
    if ({filt, rise, fall, lp, rep} !== 20'h0) $display("FAIL midreset_outputs got %h want 00000", {filt, rise, fall, lp, rep});
    else passed++;
    Reset = 1'b0;
    for (int k = 1; k <= 5000; k++) begin
      @(negedge Clock);
      if (rise[0]) begin
        rise_n++;
        rise_at = k;
      end
      if (lp[0]) begin
        lp_n++;
        lp_at = k;
      end
      if (rep[0] && rep_at < 0) rep_at = k;
    end
    total++;
    if (rise_n !== 1 || rise_at !== 6) $display("FAIL midreset_rise got %0d pulses at %0d want 1 at 6", rise_n, rise_at);
    else passed++;
    total++;
    if (lp_n !== 1 || lp_at !== 2999) $display("FAIL midreset_lp got %0d pulses at %0d want 1 at 2999", lp_n, lp_at);
    else passed++;
    total++;
    if (rep_at !== 4999) $display("FAIL midreset_rep got %0d want 4999", rep_at);
    else passed++;
    noisy[0] = 1'b0;
    repeat (10) @(negedge Clock);
  endtask

  initial begin
    test_reset();
    test_rise_ch0();
    test_glitch_ch1();
    test_long_press();
    test_active_low_ch3();
    test_simultaneous();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
